// File: rtl/mips_pkg.sv
// Shared MIPS front-end encodings: pc_src codes, NOP word, fetch states.
package mips_pkg;

  localparam logic [1:0] PC_SRC_SEQ    = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

  localparam logic [31:0] NOP_INSTR = 32'hFC00_0000;

  typedef enum logic {
    REQ  = 1'b0,
    HOLD = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_next_pc.sv
// Redirect-target select: branch/jump pick their target, others stay sequential.
module fetch_next_pc
  import mips_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [1:0]        i_pc_src,
  input  logic [ADDR_W-1:0] i_seq_pc,
  input  logic [ADDR_W-1:0] i_branch_target,
  input  logic [ADDR_W-1:0] i_jump_target,
  output logic              o_redirect,
  output logic [ADDR_W-1:0] o_target
);

  always_comb begin
    o_redirect = 1'b0;
    o_target   = i_seq_pc;
    unique case (i_pc_src)
      PC_SRC_BRANCH: begin
        o_redirect = 1'b1;
        o_target   = i_branch_target;
      end
      PC_SRC_JUMP: begin
        o_redirect = 1'b1;
        o_target   = i_jump_target;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// MIPS fetch front end: PC, imem req/ack, IF/ID register, wrong-path drop.
// Optional FETCH_PERF_CNT_EN adds stall/drop counters.
module fetch_unit
  import mips_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               flush,
  input  logic [1:0]         pc_src,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic [ADDR_W-1:0]  jump_target,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]        perf_stall_cyc,
  output logic [31:0]        perf_drop_cnt,
`endif
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc_plus4,
  output logic               if_valid
);

  localparam logic [INSTR_W-1:0] NOP = INSTR_W'(NOP_INSTR);

  fetch_state_e        r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic                r_redir_pend;
  logic [ADDR_W-1:0]   r_redir_pc;
  logic [INSTR_W-1:0]  r_hold_buf;
  logic [INSTR_W-1:0]  r_if_instr;
  logic [ADDR_W-1:0]   r_if_pc_plus4;
  logic                r_if_valid;

  logic [ADDR_W-1:0]   w_seq_pc;
  logic                w_redirect;
  logic [ADDR_W-1:0]   w_target;
  logic [ADDR_W-1:0]   w_new_pc;
  logic                w_kill;
  logic                w_load_mem;
  logic                w_load_hold;
  logic                w_drop;

  assign w_seq_pc = r_pc + ADDR_W'(4);

  fetch_next_pc #(
    .ADDR_W (ADDR_W)
  ) u_next_pc (
    .i_pc_src        (pc_src),
    .i_seq_pc        (w_seq_pc),
    .i_branch_target (branch_target),
    .i_jump_target   (jump_target),
    .o_redirect      (w_redirect),
    .o_target        (w_target)
  );

  // Newest redirect wins over a pending one; flush-only refetches r_pc.
  assign w_new_pc = w_redirect   ? w_target   :
                    r_redir_pend ? r_redir_pc : r_pc;

  assign w_kill = w_redirect | r_redir_pend | flush;

  assign w_load_mem  = (r_state == REQ) & imem_ack & ~w_kill & ~freeze;
  assign w_load_hold = (r_state == HOLD) & ~w_kill & ~freeze;
  assign w_drop      = w_kill & ((r_state == HOLD) |
                                 ((r_state == REQ) & imem_ack));

  assign imem_req    = (r_state == REQ);
  assign imem_addr   = r_pc;
  assign if_instr    = r_if_instr;
  assign if_pc_plus4 = r_if_pc_plus4;
  assign if_valid    = r_if_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= REQ;
      r_pc          <= RESET_PC;
      r_redir_pend  <= 1'b0;
      r_redir_pc    <= RESET_PC;
      r_hold_buf    <= NOP;
      r_if_instr    <= NOP;
      r_if_pc_plus4 <= '0;
      r_if_valid    <= 1'b0;
    end else begin
      unique case (r_state)
        REQ: begin
          if (imem_ack) begin
            if (w_kill) begin
              r_pc         <= w_new_pc;
              r_redir_pend <= 1'b0;
            end else if (!freeze) begin
              r_pc <= w_seq_pc;
            end else begin
              r_hold_buf <= imem_rdata;
              r_state    <= HOLD;
            end
          end else if (w_redirect) begin
            r_redir_pend <= 1'b1;
            r_redir_pc   <= w_target;
          end
        end
        HOLD: begin
          if (w_kill) begin
            r_pc         <= w_new_pc;
            r_redir_pend <= 1'b0;
            r_state      <= REQ;
          end else if (!freeze) begin
            r_pc    <= w_seq_pc;
            r_state <= REQ;
          end
        end
        default: r_state <= REQ;
      endcase

      // Unfrozen cycles without a load insert a bubble.
      if (flush) begin
        r_if_valid <= 1'b0;
        r_if_instr <= NOP;
      end else if (!freeze) begin
        if (w_load_mem) begin
          r_if_instr    <= imem_rdata;
          r_if_pc_plus4 <= w_seq_pc;
          r_if_valid    <= 1'b1;
        end else if (w_load_hold) begin
          r_if_instr    <= r_hold_buf;
          r_if_pc_plus4 <= w_seq_pc;
          r_if_valid    <= 1'b1;
        end else begin
          r_if_instr <= NOP;
          r_if_valid <= 1'b0;
        end
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_stall_cyc;
  logic [31:0] r_drop_cnt;

  assign perf_stall_cyc = r_stall_cyc;
  assign perf_drop_cnt  = r_drop_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cyc <= '0;
      r_drop_cnt  <= '0;
    end else begin
      if (freeze && (r_stall_cyc != '1))
        r_stall_cyc <= r_stall_cyc + 32'd1;
      if (w_drop && (r_drop_cnt != '1))
        r_drop_cnt <= r_drop_cnt + 32'd1;
    end
  end
`else
  logic w_unused;
  assign w_unused = w_drop;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit with a variable-latency imem model.
module tb_fetch_unit;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  pc_src = 2'd0;
  logic [31:0] branch_target = '0;
  logic [31:0] jump_target = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] if_instr;
  logic [31:0] if_pc_plus4;
  logic        if_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_stall_cyc;
  logic [31:0] perf_drop_cnt;
`endif

  fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .freeze        (freeze),
    .flush         (flush),
    .pc_src        (pc_src),
    .branch_target (branch_target),
    .jump_target   (jump_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
`ifdef FETCH_PERF_CNT_EN
    .perf_stall_cyc(perf_stall_cyc),
    .perf_drop_cnt (perf_drop_cnt),
`endif
    .if_instr      (if_instr),
    .if_pc_plus4   (if_pc_plus4),
    .if_valid      (if_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          failures = 0;
  int          loads = 0;
  int          lat = 0;
  int          acks_left = 0;
  int          cnt = 0;
  logic [31:0] sp_addr = '1;
  logic [31:0] sp_data = '0;
  logic        r_fz = 1'b0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(logic [31:0] instr, logic [31:0] pc4);
    exp_t e;
    e.instr = instr;
    e.pc4   = pc4;
    sb_q.push_back(e);
  endtask

  // imem model: data = address unless sp_addr matches; lat wait cycles.
  always begin
    @(posedge clk);
    #1;
    if (rst) begin
      cnt      = 0;
      imem_ack = 1'b0;
    end else if (imem_req && acks_left > 0) begin
      if (cnt >= lat) begin
        imem_ack   = 1'b1;
        imem_rdata = (imem_addr == sp_addr) ? sp_data : imem_addr;
        cnt        = 0;
        acks_left--;
      end else begin
        imem_ack = 1'b0;
        cnt++;
      end
    end else begin
      imem_ack = 1'b0;
      cnt      = 0;
    end
  end

  always @(posedge clk) r_fz <= freeze;

  // A valid IF/ID after an unfrozen edge is always a fresh load.
  always @(negedge clk) begin
    if (if_valid === 1'b1 && !r_fz) begin
      loads++;
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_extra: got %h/%h expected none",
                 if_instr, if_pc_plus4);
      end else begin
        mon_e = sb_q.pop_front();
        chk("sb_instr", if_instr, mon_e.instr);
        chk("sb_pc4", if_pc_plus4, mon_e.pc4);
      end
    end
  end

  task automatic do_reset();
    rst       = 1'b1;
    acks_left = 0;
    freeze    = 1'b0;
    flush     = 1'b0;
    pc_src    = 2'd0;
    sp_addr   = '1;
    repeat (2) @(negedge clk);
    rst   = 1'b0;
    loads = 0;
  endtask

  task automatic wait_loads(int n, string name);
    for (int i = 0; i < 60 && loads < n; i++) @(negedge clk);
    chk(name, 32'(loads), 32'(n));
  endtask

  task automatic drain(string name);
    repeat (2) @(negedge clk);
    chk(name, 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // 1: reset state and 0-wait sequential fetch
    lat = 0;
    do_reset();
    chk("rst_req", 32'(imem_req), 32'd1);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_instr", if_instr, 32'hFC00_0000);
    chk("rst_pc4", if_pc_plus4, 32'h0);
    push(32'h0, 32'h4);
    push(32'h4, 32'h8);
    push(32'h8, 32'hC);
    acks_left = 3;
    wait_loads(3, "t1_loads");
    drain("t1_drain");
    chk("t1_addr", imem_addr, 32'hC);
    chk("t1_req", 32'(imem_req), 32'd1);

    // 2: branch during a 3-wait request drops the 0x8 word
    do_reset();
    lat = 3;
    push(32'h0, 32'h4);
    push(32'h4, 32'h8);
    push(32'h40, 32'h44);
    acks_left = 4;
    for (int i = 0; i < 60 && imem_addr !== 32'h8; i++) @(negedge clk);
    chk("t2_at8", imem_addr, 32'h8);
    pc_src        = 2'd1;
    branch_target = 32'h40;
    @(negedge clk);
    pc_src = 2'd0;
    chk("t2_hold_a", imem_addr, 32'h8);
    @(negedge clk);
    chk("t2_hold_b", imem_addr, 32'h8);
    @(negedge clk);
    chk("t2_hold_c", imem_addr, 32'h8);
    chk("t2_ack", 32'(imem_ack), 32'd1);
    @(negedge clk);
    chk("t2_redir", imem_addr, 32'h40);
    chk("t2_valid", 32'(if_valid), 32'd0);
    wait_loads(3, "t2_loads");
    drain("t2_drain");

    // 3: freeze across an ack parks the word in HOLD
    do_reset();
    lat     = 0;
    sp_addr = 32'h4;
    sp_data = 32'h1234;
    push(32'h0, 32'h4);
    push(32'h1234, 32'h8);
    push(32'h8, 32'hC);
    acks_left = 3;
    for (int i = 0; i < 60 && !(imem_ack === 1'b1 && imem_addr === 32'h4); i++)
      @(negedge clk);
    chk("t3_ack4", imem_addr, 32'h4);
    freeze = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t3_req", 32'(imem_req), 32'd0);
      chk("t3_instr", if_instr, 32'h0);
      chk("t3_valid", 32'(if_valid), 32'd1);
    end
    freeze = 1'b0;
    @(negedge clk);
    chk("t3_rel_req", 32'(imem_req), 32'd1);
    chk("t3_rel_addr", imem_addr, 32'h8);
`ifdef FETCH_PERF_CNT_EN
    chk("t3_stall_cnt", perf_stall_cyc, 32'd4);
`endif
    wait_loads(3, "t3_loads");
    drain("t3_drain");
    sp_addr = '1;

    // 4: flush coinciding with an ack refetches the same address
    do_reset();
    lat = 0;
    push(32'h0, 32'h4);
    acks_left = 3;
    for (int i = 0; i < 60 && !(imem_ack === 1'b1 && imem_addr === 32'h4); i++)
      @(negedge clk);
    chk("t4_ack4", imem_addr, 32'h4);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("t4_valid", 32'(if_valid), 32'd0);
    chk("t4_instr", if_instr, 32'hFC00_0000);
    chk("t4_addr", imem_addr, 32'h4);
    chk("t4_req", 32'(imem_req), 32'd1);
    push(32'h4, 32'h8);
    wait_loads(2, "t4_loads");
    drain("t4_drain");

    // 5: jump to 0xFFFFFFFC, sequential address wraps to 0
    do_reset();
    lat         = 0;
    pc_src      = 2'd2;
    jump_target = 32'hFFFF_FFFC;
    @(negedge clk);
    pc_src = 2'd0;
    chk("t5_nochg", imem_addr, 32'h0);
    push(32'hFFFF_FFFC, 32'h0);
    push(32'h0, 32'h4);
    acks_left = 3;
    wait_loads(2, "t5_loads");
    drain("t5_drain");
    chk("t5_addr", imem_addr, 32'h4);
`ifdef FETCH_PERF_CNT_EN
    chk("t5_drop_cnt", perf_drop_cnt, 32'd1);
`endif

    // 6: reset while a request is outstanding
    do_reset();
    lat = 3;
    push(32'h0, 32'h4);
    acks_left = 1;
    wait_loads(1, "t6_loads");
    for (int i = 0; i < 20 && imem_addr !== 32'h4; i++) @(negedge clk);
    chk("t6_at4", imem_addr, 32'h4);
    freeze = 1'b1;
    @(negedge clk);
    freeze = 1'b0;
    rst    = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_addr", imem_addr, 32'h0);
    chk("t6_req", 32'(imem_req), 32'd1);
    chk("t6_valid", 32'(if_valid), 32'd0);
    chk("t6_instr", if_instr, 32'hFC00_0000);
`ifdef FETCH_PERF_CNT_EN
    chk("t6_stall0", perf_stall_cyc, 32'd0);
    chk("t6_drop0", perf_drop_cnt, 32'd0);
`endif
    drain("t6_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end of the 5-stage MIPS pipeline.
- Consumes the controller's redirect and flush outputs (pc_src, flush) and the hazard unit's freeze.
- Drives a variable-latency instruction-memory req/ack interface.
- Owns the PC and the IF/ID pipeline register.
- Drops wrong-path fetch responses after a redirect or flush.

Parameters:
- ADDR_W, 32, PC and memory address width.
- INSTR_W, 32, instruction width.
- RESET_PC, 0, PC loaded on reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- freeze  in  1  hazard stall; hold IF/ID and stop advancing PC.
- flush  in  1  kill the IF/ID contents and any response accepted this cycle.
- pc_src  in  2  0 = sequential, 1 = branch, 2 = jump, 3 = reserved (treated as 0).
- branch_target  in  ADDR_W  used when pc_src = 1.
- jump_target  in  ADDR_W  used when pc_src = 2.
- imem_req  out  1  fetch request.
- imem_addr  out  ADDR_W  fetch address; stable while imem_req = 1.
- imem_ack  in  1  response valid; completes the request.
- imem_rdata  in  INSTR_W  instruction; valid only with imem_ack.
- if_instr  out  INSTR_W  IF/ID instruction.
- if_pc_plus4  out  ADDR_W  IF/ID PC+4.
- if_valid  out  1  IF/ID holds a real instruction.

Behaviour:
- Reset values: state = REQ; pc = RESET_PC; fetch_addr = RESET_PC; redir_pend = 0; hold_buf = NOP; if_instr = NOP (32'hFC000000, opcode 111111); if_pc_plus4 = 0; if_valid = 0. imem_req is 1 in the first cycle after reset.
- imem_req = (state == REQ); imem_addr = fetch_addr (registered).
- Once raised, imem_req stays high and the address stays stable until imem_ack. Ack may come in the same cycle as req, giving a 0-wait response.
- Redirect = pc_src ∈ {1, 2}, sampled every cycle in every state. The target is captured into redir_pc and redir_pend is set.
- REQ, no ack: a redirect only sets redir_pend; fetch_addr does not change mid-request.
- REQ, ack, with any of redir_pend, a redirect this cycle, or flush:
  - drop the response;
  - fetch_addr/pc <= redirect target, or the same fetch_addr for a flush-only case;
  - clear redir_pend; stay in REQ.
  - A new request issues the next cycle.
- REQ, ack, clean response, freeze = 0:
  - if_instr <= imem_rdata; if_pc_plus4 <= fetch_addr + 4; if_valid <= 1;
  - fetch_addr/pc <= fetch_addr + 4; stay in REQ.
- REQ, ack, clean response, freeze = 1: hold_buf <= imem_rdata; go to HOLD (imem_req = 0).
- HOLD: when freeze = 0, load IF/ID from hold_buf, fetch_addr <= +4, go to REQ. A redirect or flush while in HOLD discards hold_buf and goes to REQ at the new PC (or same PC for flush-only).
- flush = 1: if_valid <= 0 and if_instr <= NOP at the next edge. Flush overrides freeze and any load in the same cycle.
- freeze = 1 without flush: IF/ID holds its value.
- Address arithmetic is modulo 2^ADDR_W; 32'hFFFFFFFC + 4 wraps to 0. The low two address bits are passed through unchecked.
- Reset mid-request: the request is abandoned; imem must tolerate an ack-less drop. A late ack after reset is treated as the response to the RESET_PC request, so the memory must not return stale acks after rst.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds two 32-bit output counters, reset to 0, saturating at all-ones.
  - perf_stall_cyc: cycles with freeze = 1.
  - perf_drop_cnt: discarded responses.
- Undefined: neither the ports nor the logic exist.

Decomposition:
- Shared package mips_pkg holds:
  - PC_SRC_SEQ/BRANCH/JUMP localparams;
  - the NOP_INSTR constant;
  - the fetch state enum {REQ, HOLD}.
- The controller later reuses these encodings.
- One sub-module, fetch_next_pc: combinational redirect-target select (pc_src mux, reserved code to sequential).

Test Plan:
1. rst 2 cycles, 0-wait memory returning addr as data → requests at 0, 4, 8; if_pc_plus4 = 4, 8, 12; if_valid = 1 from cycle 2.
2. 3-cycle ack latency, pc_src = 1 with branch_target = 0x40 in wait cycle 1 → imem_addr stays 0x8 until ack, response dropped, next imem_addr = 0x40, if_valid never carries the 0x8 word.
3. freeze high for 4 cycles coinciding with an ack of 0x1234 → IF/ID unchanged while frozen, state HOLD, imem_req = 0; after release if_instr = 0x1234, next request at +4.
4. flush + ack same cycle → if_valid = 0, if_instr = 0xFC000000, same address refetched.
5. Start at pc = 0xFFFFFFFC → next fetch address 0x0.
6. rst asserted while imem_req = 1 → next cycle imem_addr = RESET_PC, if_valid = 0. With FETCH_PERF_CNT_EN, counters read 0.
